// File: rtl/mem_port.sv
// -----------------------------------------------------------------------------
// mem_port
//   Data-memory access stage that sits behind the control sequencer. It
//   turns a load/store code plus a byte address into a single req/ack
//   transaction on a 32-bit word-addressed bus. It also returns aligned and
//   extended load data to the register write-data mux.
//
// Optional feature (macro MEM_PORT_TIMEOUT_EN):
//   When the macro is defined, a wait counter abandons a transaction that has
//   not been acknowledged within TIMEOUT_CYCLES REQ cycles. The abandon is
//   reported with a one-cycle bus_err pulse. When the macro is undefined,
//   REQ waits indefinitely and bus_err is tied to 0.
//
// Ports:
//   clk          system clock
//   reset        synchronous active-high reset
//   addr         byte address of the access
//   wdata        store data, right-aligned
//   read_op      LB=000 LH=001 LW=010 LBU=100 LHU=101, others = no load
//   write_op     SB=00 SH=01 SW=10 SNONE=11
//   rdata        extended load result (held between loads)
//   busy         access in progress (combinational)
//   misaligned   one-cycle pulse when an access is rejected for alignment
//   bus_req      transaction request
//   bus_we       1 = write
//   bus_addr     word address (addr[31:2])
//   bus_be       byte enables
//   bus_wdata    lane-replicated write data
//   bus_rdata    read data, valid with bus_ack
//   bus_ack      slave completion
//   bus_err      one-cycle timeout pulse (feature only)
// -----------------------------------------------------------------------------
module mem_port #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  read_op,
    input  logic [1:0]  write_op,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        misaligned,
    output logic        bus_req,
    output logic        bus_we,
    output logic [29:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Access size encoding shared by loads and stores. It equals write_op for
    // stores and read_op[1:0] for loads.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Byte enables for an access of the given size at the given byte offset.
    function automatic logic [3:0] be_for(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << lo;
            SZ_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Alignment check: halves need an even address and words need a multiple of four.
    function automatic logic misaligned_for(input logic [1:0] size, input logic [1:0] lo);
        logic bad;
        case (size)
            SZ_HALF: bad = lo[0];
            SZ_WORD: bad = (lo != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

    // Replicate store data across all lanes, so the slave only needs bus_be.
    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] lanes;
        case (size)
            SZ_BYTE: lanes = {4{wd[7:0]}};
            SZ_HALF: lanes = {2{wd[15:0]}};
            SZ_WORD: lanes = wd;
            default: lanes = 32'h0000_0000;
        endcase
        return lanes;
    endfunction

    // Pick the addressed lane out of the bus word and extend it for the load type.
    function automatic logic [31:0] load_extract(input logic [2:0] op, input logic [1:0] lane,
                                                 input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            2'd3:    b = d[31:24];
            default: b = d[7:0];
        endcase
        h = lane[1] ? d[31:16] : d[15:0];
        case (op)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b010:  r = d;
            3'b100:  r = {24'h00_0000, b};
            3'b101:  r = {16'h0000, h};
            default: r = d;
        endcase
        return r;
    endfunction

    state_t      state_r;
    logic [1:0]  lane_r;
    logic [2:0]  rop_r;

    logic        read_present_s;
    logic        write_present_s;
    logic        op_present_s;
    logic [1:0]  size_s;
    logic        misalign_s;
    logic        busy_s;

`ifdef MEM_PORT_TIMEOUT_EN
    localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 16) ? 16 : CNT_RAW);
    logic [CNT_W-1:0] wait_cnt_r;
`endif

    // Decode the presented op. When a store and a load are both present, the store wins.
    always_comb begin
        read_present_s  = !((read_op == 3'b011) || (read_op == 3'b110) || (read_op == 3'b111));
        write_present_s = (write_op != 2'b11);
        op_present_s    = read_present_s || write_present_s;
        if (write_present_s) begin
            size_s = write_op;
        end else begin
            size_s = read_op[1:0];
        end
        if (op_present_s) begin
            misalign_s = misaligned_for(size_s, addr[1:0]);
        end else begin
            misalign_s = 1'b0;
        end
    end

    // busy is raised in the same cycle an op is presented, so the sequencer
    // stalls before the request register has been loaded.
    always_comb begin
        busy_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (op_present_s) begin
                    busy_s = 1'b1;
                end else begin
                    busy_s = 1'b0;
                end
            end
            ST_REQ:  busy_s = 1'b1;
            ST_DONE: busy_s = 1'b0;
            default: busy_s = 1'b0;
        endcase
    end

    assign busy = busy_s;

    // Transaction FSM with registered bus fields, load result and status pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            rdata      <= 32'h0000_0000;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= 30'h0000_0000;
            bus_be     <= 4'b0000;
            bus_wdata  <= 32'h0000_0000;
            misaligned <= 1'b0;
            bus_err    <= 1'b0;
            lane_r     <= 2'b00;
            rop_r      <= 3'b000;
`ifdef MEM_PORT_TIMEOUT_EN
            wait_cnt_r <= '0;
`endif
        end else begin
            misaligned <= 1'b0;
            bus_err    <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (op_present_s && misalign_s) begin
                        // Rejected accesses never reach the bus.
                        misaligned <= 1'b1;
                    end else if (op_present_s) begin
                        bus_req   <= 1'b1;
                        bus_we    <= write_present_s;
                        bus_addr  <= addr[31:2];
                        bus_be    <= be_for(size_s, addr[1:0]);
                        bus_wdata <= write_present_s ? store_lanes(size_s, wdata) : 32'h0000_0000;
                        lane_r    <= addr[1:0];
                        rop_r     <= read_op;
`ifdef MEM_PORT_TIMEOUT_EN
                        wait_cnt_r <= '0;
`endif
                        state_r   <= ST_REQ;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        if (!bus_we) begin
                            rdata <= load_extract(rop_r, lane_r, bus_rdata);
                        end else begin
                            rdata <= rdata;
                        end
                        state_r <= ST_DONE;
`ifdef MEM_PORT_TIMEOUT_EN
                    end else if (wait_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        // This is the last unacknowledged cycle, so abandon the transaction.
                        bus_req <= 1'b0;
                        bus_err <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + CNT_W'(1);
                        state_r    <= ST_REQ;
                    end
`else
                    end else begin
                        state_r <= ST_REQ;
                    end
`endif
                end
                ST_DONE: begin
                    // Spend one cycle here, so an op that is still presented is not re-issued.
                    state_r <= ST_IDLE;
                end
                default: begin
                    bus_req <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port.sv
// -----------------------------------------------------------------------------
// tb_mem_port
//   Self-checking bench for mem_port. The expected bus fields and load results
//   for each transaction are pushed to a scoreboard queue when the op is
//   driven. They are popped and compared once the DUT raises bus_req and
//   reaches DONE.
// -----------------------------------------------------------------------------
module tb_mem_port;

`ifdef MEM_PORT_TIMEOUT_EN
    localparam int TB_TO = 4;
`else
    localparam int TB_TO = 255;
`endif

    localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101,
                           LNONE = 3'b111;
    localparam logic [1:0] SB = 2'b00, SH = 2'b01, SW = 2'b10, SNONE = 2'b11;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  read_op;
    logic [1:0]  write_op;
    logic [31:0] rdata;
    logic        busy;
    logic        misaligned;
    logic        bus_req;
    logic        bus_we;
    logic [29:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        bus_err;

    typedef struct {
        logic [29:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb_q[$];
    int   tests_run;
    int   tests_failed;

    mem_port #(.TIMEOUT_CYCLES(TB_TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .addr       (addr),
        .wdata      (wdata),
        .read_op    (read_op),
        .write_op   (write_op),
        .rdata      (rdata),
        .busy       (busy),
        .misaligned (misaligned),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_be     (bus_be),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .bus_ack    (bus_ack),
        .bus_err    (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one op, answer it after req_cycles REQ cycles (the last one carries
    // the ack), and check the bus fields and load result against the scoreboard.
    task automatic run_op(input string tag, input logic [2:0] rop, input logic [1:0] wop,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                          input int req_cycles, input exp_t e_in);
        exp_t e;
        int   busy_cnt;
        sb_q.push_back(e_in);
        read_op   = rop;
        write_op  = wop;
        addr      = a;
        wdata     = wd;
        bus_rdata = rd;
        #1;
        check_eq({tag, "_busy_c0"}, {31'd0, busy}, 32'd1);
        busy_cnt = busy ? 1 : 0;
        step();
        if (sb_q.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 32'd1, 32'd0);
            e = e_in;
        end else begin
            e = sb_q.pop_front();
        end
        check_eq({tag, "_addr"},  {2'b00, bus_addr}, {2'b00, e.addr});
        check_eq({tag, "_be"},    {28'd0, bus_be},   {28'd0, e.be});
        check_eq({tag, "_we"},    {31'd0, bus_we},   {31'd0, e.we});
        check_eq({tag, "_wdata"}, bus_wdata,         e.wdata);
        for (int i = 1; i <= req_cycles; i++) begin
            check_eq({tag, "_req"}, {31'd0, bus_req}, 32'd1);
            if (busy) busy_cnt++;
            bus_ack = (i == req_cycles);
            step();
        end
        bus_ack = 1'b0;
        check_eq({tag, "_req_drop"}, {31'd0, bus_req}, 32'd0);
        check_eq({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
        check_eq({tag, "_rdata"}, rdata, e.rdata);
        check_eq({tag, "_busy_cnt"}, busy_cnt, req_cycles + 1);
        read_op  = LNONE;
        write_op = SNONE;
        step();
    endtask

    // Present an op for one cycle and expect it to be rejected.
    task automatic run_misaligned(input string tag, input logic [2:0] rop, input logic [1:0] wop,
                                  input logic [31:0] a, input logic [31:0] keep_rdata);
        read_op  = rop;
        write_op = wop;
        addr     = a;
        #1;
        check_eq({tag, "_busy_c0"}, {31'd0, busy}, 32'd1);
        step();
        read_op  = LNONE;
        write_op = SNONE;
        #1;
        check_eq({tag, "_pulse"}, {31'd0, misaligned}, 32'd1);
        check_eq({tag, "_noreq"}, {31'd0, bus_req}, 32'd0);
        check_eq({tag, "_busy"},  {31'd0, busy}, 32'd0);
        step();
        check_eq({tag, "_pulse_end"}, {31'd0, misaligned}, 32'd0);
        check_eq({tag, "_noreq2"}, {31'd0, bus_req}, 32'd0);
        check_eq({tag, "_rdata"}, rdata, keep_rdata);
    endtask

    initial begin
        int req_cnt;
        tests_run    = 0;
        tests_failed = 0;
        reset     = 1'b1;
        addr      = 32'd0;
        wdata     = 32'd0;
        read_op   = LNONE;
        write_op  = SNONE;
        bus_rdata = 32'd0;
        bus_ack   = 1'b0;
        step();
        step();
        check_eq("rst_req",   {31'd0, bus_req}, 32'd0);
        check_eq("rst_rdata", rdata, 32'd0);
        check_eq("rst_mis",   {31'd0, misaligned}, 32'd0);
        check_eq("rst_err",   {31'd0, bus_err}, 32'd0);
        check_eq("rst_be",    {28'd0, bus_be}, 32'd0);
        check_eq("rst_busy",  {31'd0, busy}, 32'd0);
        reset = 1'b0;
        step();

        run_op("lw",  LW,  SNONE, 32'h100, 32'h0, 32'hDEADBEEF, 3,
               '{addr: 30'h40, be: 4'b1111, we: 1'b0, wdata: 32'h0, rdata: 32'hDEADBEEF});
        run_op("lb",  LB,  SNONE, 32'h203, 32'h0, 32'h80112233, 1,
               '{addr: 30'h80, be: 4'b1000, we: 1'b0, wdata: 32'h0, rdata: 32'hFFFFFF80});
        run_op("lbu", LBU, SNONE, 32'h203, 32'h0, 32'h80112233, 1,
               '{addr: 30'h80, be: 4'b1000, we: 1'b0, wdata: 32'h0, rdata: 32'h00000080});
        run_op("sh",  LNONE, SH,  32'h12, 32'h0000A5C3, 32'h0, 1,
               '{addr: 30'h4, be: 4'b1100, we: 1'b1, wdata: 32'hA5C3A5C3, rdata: 32'h00000080});
        run_op("lh",  LH,  SNONE, 32'h202, 32'h0, 32'h80112233, 2,
               '{addr: 30'h80, be: 4'b1100, we: 1'b0, wdata: 32'h0, rdata: 32'hFFFF8011});
        run_op("lhu", LHU, SNONE, 32'h200, 32'h0, 32'h8011A233, 1,
               '{addr: 30'h80, be: 4'b0011, we: 1'b0, wdata: 32'h0, rdata: 32'h0000A233});
        run_op("sb",  LNONE, SB,  32'h1, 32'hFFFF005A, 32'h0, 1,
               '{addr: 30'h0, be: 4'b0010, we: 1'b1, wdata: 32'h5A5A5A5A, rdata: 32'h0000A233});
        run_op("both", LW, SW,    32'h8, 32'h12345678, 32'hCAFEF00D, 1,
               '{addr: 30'h2, be: 4'b1111, we: 1'b1, wdata: 32'h12345678, rdata: 32'h0000A233});

        run_misaligned("mis_lw", LW, SNONE, 32'h102, 32'h0000A233);
        run_misaligned("mis_sh", LNONE, SH, 32'h13, 32'h0000A233);

        // Reset in the second REQ cycle, followed by a late ack.
        read_op  = LW;
        write_op = SNONE;
        addr     = 32'h20;
        step();
        check_eq("rstreq_req1", {31'd0, bus_req}, 32'd1);
        step();
        check_eq("rstreq_req2", {31'd0, bus_req}, 32'd1);
        reset    = 1'b1;
        read_op  = LNONE;
        step();
        reset = 1'b0;
        check_eq("rstreq_drop", {31'd0, bus_req}, 32'd0);
        check_eq("rstreq_busy", {31'd0, busy}, 32'd0);
        bus_rdata = 32'h55AA55AA;
        bus_ack   = 1'b1;
        step();
        bus_ack = 1'b0;
        step();
        check_eq("late_ack_rdata", rdata, 32'd0);
        check_eq("late_ack_req",   {31'd0, bus_req}, 32'd0);
        check_eq("late_ack_busy",  {31'd0, busy}, 32'd0);

        // A load that is never acknowledged.
        read_op = LW;
        addr    = 32'h40;
        step();
        read_op = LNONE;
`ifdef MEM_PORT_TIMEOUT_EN
        req_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus_req) req_cnt++;
            check_eq("to_no_err", {31'd0, bus_err}, 32'd0);
            step();
        end
        check_eq("to_req_cycles", req_cnt, 4);
        check_eq("to_err",   {31'd0, bus_err}, 32'd1);
        check_eq("to_req",   {31'd0, bus_req}, 32'd0);
        check_eq("to_busy",  {31'd0, busy}, 32'd0);
        check_eq("to_rdata", rdata, 32'd0);
        step();
        check_eq("to_err_end", {31'd0, bus_err}, 32'd0);
`else
        req_cnt = 0;
        for (int i = 0; i < 120; i++) begin
            if (bus_req && busy) req_cnt++;
            step();
        end
        check_eq("noack_hold", req_cnt, 120);
        check_eq("noack_err", {31'd0, bus_err}, 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("noack_rst", {31'd0, bus_req}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
